// File: rtl/queue_display.sv
// Multiplexed 4-digit common-anode 7-segment front end for the bank queue counter.
// Pcount/Pwait are converted to BCD once per frame by a sequential double-dabble FSM.
module queue_display #(
  parameter int unsigned N        = 3,
  parameter int unsigned WAIT_W   = 6,
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N:0]        Pcount,
  input  logic [WAIT_W-1:0] Pwait,
  input  logic              emptyFlag,
  input  logic              fullFlag,
  output logic [6:0]        seg,
  output logic [3:0]        an,
  output logic              dp,
  output logic              busy
);

  localparam int unsigned CW    = ((N + 1) > WAIT_W) ? (N + 1) : WAIT_W;
  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(CW + 1);
  localparam int unsigned SH_W  = 8 + CW;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, COMMIT} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div;
  logic [1:0]        idx;
  logic              div_wrap, frame_start;
  logic [DIV_W-1:0]  div_nxt;
  logic [1:0]        idx_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [CW-1:0]     bin_c, bin_w;
  logic [7:0]        bcd_c, bcd_w;
  logic              cap_empty, cap_full;
  logic [SH_W-1:0]   sh_c, sh_w;

  logic [7:0]        disp_c, disp_w;
  logic              disp_empty, disp_full, disp_valid;
  logic              dp_hold;
  logic [6:0]        seg_sel;
  logic              dp_sel;

  function automatic logic [7:0] dabble_adj(input logic [7:0] b);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = b[3:0];
    hi = b[7:4];
    if (lo >= 4'd5) lo = lo + 4'd3;
    if (hi >= 4'd5) hi = hi + 4'd3;
    return {hi, lo};
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Scan timing: digit period counter and digit index
  always_comb begin
    div_wrap    = (div == DIV_W'(SCAN_DIV - 1));
    div_nxt     = div_wrap ? '0 : div + DIV_W'(1);
    idx_nxt     = div_wrap ? idx + 2'd1 : idx;
    frame_start = div_wrap && (idx == 2'd3);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div <= '0;
      idx <= '0;
    end else begin
      div <= div_nxt;
      idx <= idx_nxt;
    end
  end

  // Conversion FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = CAPTURE;
      CAPTURE: state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(CW - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One double-dabble step for each converter: adjust nibbles, then shift {bcd,bin} left
  always_comb begin
    sh_c = {dabble_adj(bcd_c), bin_c} << 1;
    sh_w = {dabble_adj(bcd_w), bin_w} << 1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      bin_c      <= '0;
      bin_w      <= '0;
      bcd_c      <= '0;
      bcd_w      <= '0;
      cap_empty  <= 1'b0;
      cap_full   <= 1'b0;
      disp_c     <= '0;
      disp_w     <= '0;
      disp_empty <= 1'b0;
      disp_full  <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          bin_c     <= CW'(Pcount);
          bin_w     <= CW'(Pwait);
          cap_empty <= emptyFlag;
          cap_full  <= fullFlag;
          bcd_c     <= '0;
          bcd_w     <= '0;
          cnt       <= '0;
        end
        SHIFT: begin
          bcd_c <= sh_c[SH_W-1:CW];
          bin_c <= sh_c[CW-1:0];
          bcd_w <= sh_w[SH_W-1:CW];
          bin_w <= sh_w[CW-1:0];
          cnt   <= cnt + CNT_W'(1);
        end
        COMMIT: begin
          disp_c     <= bcd_c;
          disp_w     <= bcd_w;
          disp_empty <= cap_empty;
          disp_full  <= cap_full;
          disp_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Segment pattern for the digit period about to start
  always_comb begin
    seg_sel = SEG_BLANK;
    dp_sel  = 1'b1;
    if (disp_valid) begin
      case (idx_nxt)
        2'd3:    seg_sel = (disp_c[7:4] == 4'd0) ? SEG_BLANK : enc(disp_c[7:4]);
        2'd2:    seg_sel = enc(disp_c[3:0]);
        2'd1:    seg_sel = disp_empty ? SEG_DASH :
                           ((disp_w[7:4] == 4'd0) ? SEG_BLANK : enc(disp_w[7:4]));
        default: seg_sel = disp_empty ? SEG_DASH : enc(disp_w[3:0]);
      endcase
      dp_sel = ~(disp_full && (idx_nxt == 2'd3));
    end
  end

  // Segments/dp latched once per digit period; anodes dark in its first cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg     <= SEG_BLANK;
      an      <= 4'hF;
      dp      <= 1'b1;
      dp_hold <= 1'b1;
      busy    <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (div_wrap) begin
        an      <= 4'hF;
        seg     <= seg_sel;
        dp      <= 1'b1;
        dp_hold <= dp_sel;
      end else begin
        an <= ~(4'b0001 << idx);
        dp <= dp_hold;
      end
    end
  end

endmodule

// File: tb/tb_queue_display.sv
// Directed bench for queue_display: reference digits are computed arithmetically,
// queued when stimulus is applied and popped when the matching anode is driven.
module tb_queue_display;

  localparam int unsigned N        = 3;
  localparam int unsigned WAIT_W   = 6;
  localparam int unsigned SCAN_DIV = 16;
  localparam int unsigned FRAME    = 4 * SCAN_DIV;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [N:0]        Pcount = '0;
  logic [WAIT_W-1:0] Pwait = '0;
  logic              emptyFlag = 1'b0;
  logic              fullFlag = 1'b0;
  logic [6:0]        seg;
  logic [3:0]        an;
  logic              dp;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] sb_q[$];

  queue_display #(.N(N), .WAIT_W(WAIT_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clock(clock), .reset(reset), .Pcount(Pcount), .Pwait(Pwait),
    .emptyFlag(emptyFlag), .fullFlag(fullFlag),
    .seg(seg), .an(an), .dp(dp), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected {an, seg, dp} while digit d is lit; 10 = dash, 11 = blank
  task automatic push_digit(input int d, input int pc, input int pw, input bit e, input bit f);
    int sym;
    logic [3:0] a;
    case (d)
      3:       sym = (pc / 10 == 0) ? 11 : pc / 10;
      2:       sym = pc % 10;
      1:       sym = e ? 10 : ((pw / 10 == 0) ? 11 : pw / 10);
      default: sym = e ? 10 : pw % 10;
    endcase
    a = 4'b0001 << d;
    sb_q.push_back({~a, code(sym), ~(f && d == 3)});
  endtask

  task automatic wait_an(input logic [3:0] t);
    for (int i = 0; i < 3 * FRAME && an !== t; i++) tick();
    check("wait_an", {12'h0, an}, {12'h0, t});
  endtask

  task automatic wait_busy(input logic v);
    for (int i = 0; i < 3 * FRAME && busy !== v; i++) tick();
    check("wait_busy", {15'h0, busy}, {15'h0, v});
  endtask

  task automatic check_next(input string tag);
    logic [11:0] e;
    e = sb_q.pop_front();
    wait_an(e[11:8]);
    check(tag, {4'h0, an, seg, dp}, {4'h0, e});
  endtask

  task automatic set_in(input int pc, input int pw, input bit e, input bit f);
    Pcount    = (N + 1)'(pc);
    Pwait     = WAIT_W'(pw);
    emptyFlag = e;
    fullFlag  = f;
  endtask

  initial begin
    int bcount;
    logic [3:0] a_exp;

    // T1: reset values, then scan pattern with blank gaps and no digits yet
    repeat (3) tick();
    check("rst_seg", {9'h0, seg}, 16'h007F);
    check("rst_an", {12'h0, an}, 16'h000F);
    check("rst_dp", {15'h0, dp}, 16'h0001);
    check("rst_busy", {15'h0, busy}, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      a_exp = 4'b0001 << ((k / SCAN_DIV) % 4);
      a_exp = ((k % SCAN_DIV) == 0) ? 4'hF : ~a_exp;
      check("scan_an", {12'h0, an}, {12'h0, a_exp});
      check("blank_seg", {9'h0, seg}, 16'h007F);
    end

    // T2: single-digit values with leading-zero blanking
    set_in(5, 9, 1'b0, 1'b0);
    repeat (2 * FRAME) tick();
    for (int d = 0; d < 4; d++) push_digit(d, 5, 9, 1'b0, 1'b0);
    for (int d = 0; d < 4; d++) check_next("t2_digit");

    // T3: two-digit values, full flag drives dp on digit 3 only
    set_in(15, 63, 1'b0, 1'b1);
    repeat (2 * FRAME) tick();
    for (int d = 0; d < 4; d++) push_digit(d, 15, 63, 1'b0, 1'b1);
    for (int d = 0; d < 4; d++) check_next("t3_digit");
    for (int k = 0; k < FRAME; k++) begin
      tick();
      check("t3_dp", {15'h0, dp}, {15'h0, an !== 4'b0111});
    end
    wait_busy(1'b0);
    wait_busy(1'b1);
    bcount = 0;
    while (busy === 1'b1 && bcount < 20) begin
      bcount++;
      tick();
    end
    check("t3_busy_len", 16'(bcount), 16'd8);

    // T4: empty queue shows dashes on the wait pair
    set_in(0, 0, 1'b1, 1'b0);
    repeat (2 * FRAME) tick();
    for (int d = 0; d < 4; d++) push_digit(d, 0, 0, 1'b1, 1'b0);
    for (int d = 0; d < 4; d++) check_next("t4_digit");

    // T5: input change right after the snapshot waits for the next frame
    set_in(3, 0, 1'b0, 1'b0);
    repeat (2 * FRAME) tick();
    wait_busy(1'b0);
    wait_busy(1'b1);
    tick();
    set_in(12, 0, 1'b0, 1'b0);
    wait_busy(1'b0);
    push_digit(2, 3, 0, 1'b0, 1'b0);
    push_digit(3, 3, 0, 1'b0, 1'b0);
    check_next("t5_old");
    check_next("t5_old");
    push_digit(2, 12, 0, 1'b0, 1'b0);
    push_digit(3, 12, 0, 1'b0, 1'b0);
    check_next("t5_new");
    check_next("t5_new");

    // T6: reset mid-conversion aborts; first commit afterwards is clean
    set_in(9, 0, 1'b0, 1'b0);
    wait_busy(1'b0);
    wait_busy(1'b1);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("t6_seg", {9'h0, seg}, 16'h007F);
    check("t6_an", {12'h0, an}, 16'h000F);
    check("t6_dp", {15'h0, dp}, 16'h0001);
    check("t6_busy", {15'h0, busy}, 16'h0000);
    repeat (2) tick();
    @(negedge clock);
    reset = 1'b1;
    wait_an(4'b1011);
    check("t6_blank", {9'h0, seg}, 16'h007F);
    wait_busy(1'b1);
    wait_busy(1'b0);
    for (int d = 1; d < 4; d++) push_digit(d, 9, 0, 1'b0, 1'b0);
    push_digit(0, 9, 0, 1'b0, 1'b0);
    for (int d = 0; d < 4; d++) check_next("t6_digit");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
